ram_arbiter: RTL and testbench

Two-port arbiter that shares one single-port synchronous `ram` instance (1-cycle read latency, active-low write enable) between the Z80 CPU and the video fetcher. Video has fixed priority to honour display timing; a starvation counter guarantees the CPU a slot after a bounded wait. Sits between the CPU/video bus logic and the RAM macro; drives the RAM's `ce`, `we`, `a` and `d` and demultiplexes its `q`.

---
 rtl/ram_arb_pkg.sv | 33 +++
 rtl/starve_counter.sv | 30 +++
 rtl/ram_arbiter.sv | 112 +++++++++++
 tb/tb_ram_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the CPU/video RAM arbiter: FSM states, bus owner,
// starvation defaults and the arbitration priority rule.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } owner_t;

   localparam int             STARVE_DEFAULT = 8;
   localparam int             CNT_W          = 8;
   localparam logic [CNT_W-1:0] CNT_MAX      = 8'hFF;

   // Video normally wins a tie; a starved CPU overrides it.
   function automatic owner_t pick_owner(input logic cpu_req,
                                         input logic vid_req,
                                         input logic starved);
      if (cpu_req && (!vid_req || starved))
         return OWN_CPU;
      else if (vid_req)
         return OWN_VID;
      else
         return OWN_NONE;
   endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of cycles the CPU has waited; flags when the wait
// reaches the STARVE threshold so the CPU can pre-empt video.
module starve_counter
   import ram_arb_pkg::*;
#(
   parameter int STARVE = STARVE_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic starved
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != CNT_MAX))
         count <= count + 1'b1;
   end

   assign starved = (count >= LIMIT);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read, active-low write)
// between the Z80 CPU and the video fetcher; one access per three cycles.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW     = 14,
   parameter int STARVE = STARVE_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_a,
   input  logic [7:0]    cpu_d,
   output logic [7:0]    cpu_q,
   output logic          cpu_ack,
   output logic          cpu_wait,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_a,
   output logic [7:0]    vid_q,
   output logic          vid_ack,
   output logic          ram_ce,
   output logic          ram_we,
   output logic [AW-1:0] ram_a,
   output logic [7:0]    ram_d,
   input  logic [7:0]    ram_q
);

   state_t state;
   owner_t owner;
   owner_t pick;
   logic   starved;
   logic   cpu_grant;

   assign pick      = pick_owner(cpu_req, vid_req, starved);
   assign cpu_grant = (state == ST_IDLE) && (pick == OWN_CPU);
   assign cpu_wait  = cpu_req & ~cpu_ack;

   // Counts every cycle the CPU asks but is not granted, including
   // cycles spent waiting for another owner's access to finish.
   starve_counter #(
      .STARVE (STARVE)
   ) u_starve (
      .clock   (clock),
      .reset   (reset),
      .inc     (cpu_req & ~cpu_grant),
      .clr     (~cpu_req | cpu_grant),
      .starved (starved)
   );

   // The RAM-side registers double as the latched request, so the
   // requester may change its address/data right after the grant edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         owner   <= OWN_NONE;
         ram_ce  <= 1'b0;
         ram_we  <= 1'b1;
         ram_a   <= '0;
         ram_d   <= '0;
         cpu_q   <= '0;
         vid_q   <= '0;
         cpu_ack <= 1'b0;
         vid_ack <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         vid_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick == OWN_CPU) begin
                  owner  <= OWN_CPU;
                  state  <= ST_ISSUE;
                  ram_ce <= 1'b1;
                  ram_we <= ~cpu_wr;
                  ram_a  <= cpu_a;
                  ram_d  <= cpu_d;
               end else if (pick == OWN_VID) begin
                  owner  <= OWN_VID;
                  state  <= ST_ISSUE;
                  ram_ce <= 1'b1;
                  ram_we <= 1'b1;
                  ram_a  <= vid_a;
               end
            end
            ST_ISSUE: begin
               ram_ce <= 1'b0;
               ram_we <= 1'b1;
               state  <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // A CPU write also returns the pre-write contents.
               if (owner == OWN_CPU) begin
                  cpu_q   <= ram_q;
                  cpu_ack <= 1'b1;
               end else if (owner == OWN_VID) begin
                  vid_q   <= ram_q;
                  vid_ack <= 1'b1;
               end
               owner <= OWN_NONE;
               state <= ST_IDLE;
            end
            default: begin
               owner  <= OWN_NONE;
               ram_ce <= 1'b0;
               ram_we <= 1'b1;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-before-write RAM.
module tb_ram_arbiter;

   localparam int AW = 14;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_wr = 1'b0;
   logic [AW-1:0] cpu_a = '0;
   logic [7:0]    cpu_d = '0;
   logic [7:0]    cpu_q;
   logic          cpu_ack;
   logic          cpu_wait;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_a = '0;
   logic [7:0]    vid_q;
   logic          vid_ack;
   logic          ram_ce;
   logic          ram_we;
   logic [AW-1:0] ram_a;
   logic [7:0]    ram_d;
   logic [7:0]    ram_q = '0;

   logic [7:0] mem [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ram_arbiter #(.AW(AW), .STARVE(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_wr   (cpu_wr),
      .cpu_a    (cpu_a),
      .cpu_d    (cpu_d),
      .cpu_q    (cpu_q),
      .cpu_ack  (cpu_ack),
      .cpu_wait (cpu_wait),
      .vid_req  (vid_req),
      .vid_a    (vid_a),
      .vid_q    (vid_q),
      .vid_ack  (vid_ack),
      .ram_ce   (ram_ce),
      .ram_we   (ram_we),
      .ram_a    (ram_a),
      .ram_d    (ram_d),
      .ram_q    (ram_q)
   );

   always @(posedge clock) begin
      if (ram_ce) begin
         ram_q <= mem[ram_a];
         if (!ram_we) mem[ram_a] <= ram_d;
      end
   end

   typedef struct {
      logic          is_vid;
      logic          wr;
      logic [AW-1:0] addr;
      logic [7:0]    d;
      logic [7:0]    exp_q;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ram_ce"}, 32'(ram_ce), 0);
      chk({tag, " ram_we"}, 32'(ram_we), 1);
      chk({tag, " ram_a"}, 32'(ram_a), 0);
      chk({tag, " ram_d"}, 32'(ram_d), 0);
      chk({tag, " cpu_q"}, 32'(cpu_q), 0);
      chk({tag, " vid_q"}, 32'(vid_q), 0);
      chk({tag, " cpu_ack"}, 32'(cpu_ack), 0);
      chk({tag, " vid_ack"}, 32'(vid_ack), 0);
   endtask

   // Single access from IDLE; inputs scrambled after grant to prove latching.
   task automatic run_access(input vec_t v, input string tag);
      if (v.is_vid) begin
         vid_req = 1'b1; vid_a = v.addr;
      end else begin
         cpu_req = 1'b1; cpu_wr = v.wr; cpu_a = v.addr; cpu_d = v.d;
      end
      #1;
      chk({tag, " wait n"}, 32'(cpu_wait), 32'(!v.is_vid));
      chk({tag, " ce n"}, 32'(ram_ce), 0);
      step();
      cpu_a = ~v.addr; cpu_d = ~v.d; cpu_wr = ~v.wr; vid_a = ~v.addr;
      chk({tag, " ce n+1"}, 32'(ram_ce), 1);
      chk({tag, " a n+1"}, 32'(ram_a), 32'(v.addr));
      chk({tag, " we n+1"}, 32'(ram_we), 32'(!(v.wr && !v.is_vid)));
      if (v.wr && !v.is_vid) chk({tag, " d n+1"}, 32'(ram_d), 32'(v.d));
      step();
      chk({tag, " ce n+2"}, 32'(ram_ce), 0);
      chk({tag, " we n+2"}, 32'(ram_we), 1);
      chk({tag, " ack n+2"}, 32'(cpu_ack | vid_ack), 0);
      chk({tag, " wait n+2"}, 32'(cpu_wait), 32'(!v.is_vid));
      step();
      if (v.is_vid) begin
         chk({tag, " vid_ack n+3"}, 32'(vid_ack), 1);
         chk({tag, " vid_q n+3"}, 32'(vid_q), 32'(v.exp_q));
         chk({tag, " cpu_ack n+3"}, 32'(cpu_ack), 0);
         vid_req = 1'b0;
      end else begin
         chk({tag, " cpu_ack n+3"}, 32'(cpu_ack), 1);
         chk({tag, " cpu_q n+3"}, 32'(cpu_q), 32'(v.exp_q));
         chk({tag, " wait n+3"}, 32'(cpu_wait), 0);
         chk({tag, " vid_ack n+3"}, 32'(vid_ack), 0);
         cpu_req = 1'b0;
      end
      step();
      chk({tag, " ack n+4"}, 32'(cpu_ack | vid_ack), 0);
      if (v.is_vid) chk({tag, " vid_q held"}, 32'(vid_q), 32'(v.exp_q));
      else          chk({tag, " cpu_q held"}, 32'(cpu_q), 32'(v.exp_q));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          v;
      logic [7:0]    b2b [4];

      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
      mem[14'h1234] = 8'hA5;
      mem[14'h0100] = 8'h3C;
      mem[14'h3FFF] = 8'h11;
      mem[14'h0040] = 8'h77;
      mem[14'h0050] = 8'h88;
      mem[14'h0060] = 8'h99;
      mem[14'h0070] = 8'h66;
      mem[14'h0000] = 8'h10;
      mem[14'h0001] = 8'h21;
      mem[14'h0002] = 8'h32;
      mem[14'h0003] = 8'h43;
      mem[14'h0020] = 8'hC3;
      b2b[0] = 8'h10; b2b[1] = 8'h21; b2b[2] = 8'h32; b2b[3] = 8'h43;

      //            is_vid wr    addr       d      exp_q
      vecs[0] = '{1'b0, 1'b0, 14'h1234, 8'h00, 8'hA5};
      vecs[1] = '{1'b0, 1'b1, 14'h0010, 8'h5A, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 14'h0010, 8'h00, 8'h5A};
      vecs[3] = '{1'b1, 1'b0, 14'h0100, 8'h00, 8'h3C};
      vecs[4] = '{1'b0, 1'b1, 14'h3FFF, 8'hFF, 8'h11};
      vecs[5] = '{1'b1, 1'b0, 14'h3FFF, 8'h00, 8'hFF};

      step();
      step();
      chk_reset_vals("reset");
      chk("reset wait", 32'(cpu_wait), 0);
      reset = 1'b0;
      step();

      for (int k = 0; k < 6; k++) begin
         run_access(vecs[k], $sformatf("vec%0d", k));
         step();
      end

      // Contention: video first, CPU in the following slot.
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h0040;
      vid_req = 1'b1; vid_a = 14'h0050;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk($sformatf("cont vid_ack c%0d", i), 32'(vid_ack), 32'(i == 3));
         chk($sformatf("cont cpu_ack c%0d", i), 32'(cpu_ack), 32'(i == 6));
         if (i == 1) chk("cont ram_a vid", 32'(ram_a), 32'h0050);
         if (i == 4) chk("cont ram_a cpu", 32'(ram_a), 32'h0040);
         if (i == 5) chk("cont wait", 32'(cpu_wait), 1);
         if (i == 3) begin chk("cont vid_q", 32'(vid_q), 32'h88); vid_req = 1'b0; end
         if (i == 6) begin chk("cont cpu_q", 32'(cpu_q), 32'h77); cpu_req = 1'b0; end
      end
      step();

      // Starvation with STARVE=4: two video slots, then CPU, then video again.
      vid_req = 1'b1; vid_a = 14'h0060;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h0070;
      for (int i = 1; i <= 13; i++) begin
         step();
         chk($sformatf("starve vid_ack c%0d", i), 32'(vid_ack), 32'(i == 3 || i == 6 || i == 12));
         chk($sformatf("starve cpu_ack c%0d", i), 32'(cpu_ack), 32'(i == 9));
         if (i == 1)  chk("starve ram_a c1", 32'(ram_a), 32'h0060);
         if (i == 4)  chk("starve ram_a c4", 32'(ram_a), 32'h0060);
         if (i == 7)  chk("starve ram_a c7", 32'(ram_a), 32'h0070);
         if (i == 10) chk("starve ram_a c10", 32'(ram_a), 32'h0060);
         if (i == 9) begin chk("starve cpu_q", 32'(cpu_q), 32'h66); cpu_req = 1'b0; end
         if (i == 12) begin chk("starve vid_q", 32'(vid_q), 32'h99); vid_req = 1'b0; end
      end
      step();

      // Back-to-back video over 0x0000..0x0003.
      vid_req = 1'b1; vid_a = 14'h0000;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk($sformatf("b2b vid_ack c%0d", i), 32'(vid_ack), 32'(i % 3 == 0));
         if (i % 3 == 1) chk($sformatf("b2b ram_a c%0d", i), 32'(ram_a), 32'((i - 1) / 3));
         if (i % 3 == 0) begin
            chk($sformatf("b2b vid_q c%0d", i), 32'(vid_q), 32'(b2b[i / 3 - 1]));
            if (i < 12) vid_a = AW'(i / 3);
            else        vid_req = 1'b0;
         end
      end
      step();

      // Reset asserted mid-ISSUE of a CPU write.
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a = 14'h0020; cpu_d = 8'hEE;
      step();
      chk("rst issue ce", 32'(ram_ce), 1);
      #2 reset = 1'b1;
      #1;
      chk("rst async ce", 32'(ram_ce), 0);
      cpu_req = 1'b0; cpu_wr = 1'b0;
      step();
      chk_reset_vals("rst mid");
      chk("rst mem unchanged", 32'(mem[14'h0020]), 32'hC3);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rst no ack c%0d", i), 32'(cpu_ack | vid_ack), 0);
      end
      v = '{1'b0, 1'b0, 14'h0020, 8'h00, 8'hC3};
      run_access(v, "post-rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
